// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per clock,
// result {remainder, quotient} held until the requester drops start_i.
module div_unit #(
   parameter int DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  signed_div_i,
   input  logic [DATA_W-1:0]     opdata1_i,
   input  logic [DATA_W-1:0]     opdata2_i,
   input  logic                  start_i,
   input  logic                  annul_i,
   output logic [2*DATA_W-1:0]   result_o,
   output logic                  ready_o,
   output logic [1:0]            dbg_state_o
);

   localparam int CW = $clog2(DATA_W + 1);
   localparam logic [CW-1:0] LAST = CW'(DATA_W);

   typedef enum logic [1:0] {
      S_FREE   = 2'd0,
      S_BYZERO = 2'd1,
      S_ON     = 2'd2,
      S_END    = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [2*DATA_W:0]   work_q, work_d;
   logic [DATA_W-1:0]   divisor_q, divisor_d;
   logic                neg_quo_q, neg_quo_d;
   logic                neg_rem_q, neg_rem_d;
   logic [2*DATA_W-1:0] result_q, result_d;

   logic                accept;
   logic [DATA_W-1:0]   abs_a, abs_b;
   logic [DATA_W+1:0]   trial;
   logic [DATA_W-1:0]   quo, rem;

   assign accept = start_i & ~annul_i;
   assign abs_a  = (signed_div_i & opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
   assign abs_b  = (signed_div_i & opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
   // Partial remainder (shifted, with next dividend bit) minus divisor; MSB is the borrow.
   assign trial  = {1'b0, work_q[2*DATA_W:DATA_W]} - {2'b00, divisor_q};
   assign quo    = work_q[DATA_W-1:0];
   assign rem    = work_q[2*DATA_W:DATA_W+1];

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_FREE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FREE: begin
            if (accept) begin
               state_d = (opdata2_i == '0) ? S_BYZERO : S_ON;
            end
         end
         S_BYZERO: state_d = S_END;
         S_ON: begin
            if (annul_i) begin
               state_d = S_FREE;
            end else if (cnt_q == LAST) begin
               state_d = S_END;
            end
         end
         S_END: begin
            if (!start_i) begin
               state_d = S_FREE;
            end
         end
         default: state_d = S_FREE;
      endcase
   end

   // Outputs
   always_comb begin
      ready_o     = (state_q == S_END);
      result_o    = (state_q == S_END) ? result_q : '0;
      dbg_state_o = state_q;
   end

   // Datapath next-state
   always_comb begin
      cnt_d     = cnt_q;
      work_d    = work_q;
      divisor_d = divisor_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      result_d  = result_q;
      case (state_q)
         S_FREE: begin
            result_d = '0;
            if (accept) begin
               cnt_d     = '0;
               work_d    = {{DATA_W{1'b0}}, abs_a, 1'b0};
               divisor_d = abs_b;
               neg_quo_d = signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
               neg_rem_d = signed_div_i & opdata1_i[DATA_W-1];
            end
         end
         S_BYZERO: result_d = '0;
         S_ON: begin
            if (!annul_i) begin
               if (cnt_q != LAST) begin
                  if (trial[DATA_W+1]) begin
                     work_d = {work_q[2*DATA_W-1:0], 1'b0};
                  end else begin
                     work_d = {trial[DATA_W-1:0], work_q[DATA_W-1:0], 1'b1};
                  end
                  cnt_d = cnt_q + CW'(1);
               end else begin
                  result_d = {(neg_rem_q ? -rem : rem), (neg_quo_q ? -quo : quo)};
               end
            end
         end
         S_END: begin
            if (!start_i) begin
               result_d = '0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= '0;
         work_q    <= '0;
         divisor_q <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         result_q  <= '0;
      end else begin
         cnt_q     <= cnt_d;
         work_q    <= work_d;
         divisor_q <= divisor_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         result_q  <= result_d;
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed divisions, expected results and ready cycles
// queued by the driver, popped and compared by a monitor on each ready rise.
module tb_div_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        signed_div;
   logic [31:0] op1, op2;
   logic        start, annul;
   logic [63:0] result_o;
   logic        ready_o;
   logic [1:0]  dbg_state_o;

   logic [63:0] exp_q[$];
   int          cyc_q[$];
   int          cyc = 0;
   int          n_total = 0;
   int          n_pass = 0;
   logic        ready_prev = 1'b0;

   div_unit #(.DATA_W(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div),
      .opdata1_i    (op1),
      .opdata2_i    (op2),
      .start_i      (start),
      .annul_i      (annul),
      .result_o     (result_o),
      .ready_o      (ready_o),
      .dbg_state_o  (dbg_state_o)
   );

   // Clock / reset
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog act=running exp=finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s act=%h exp=%h at cycle %0d", name, act, exp, cyc);
      end else begin
         n_pass++;
      end
   endtask

   // Monitor / scoreboard
   always @(negedge clk) begin
      logic [63:0] e;
      int          c;
      if (rst) begin
         ready_prev = 1'b0;
      end else begin
         if (ready_o && !ready_prev) begin
            if (exp_q.size() == 0) begin
               check("unexpected_ready", {63'd0, ready_o}, 64'd0);
            end else begin
               e = exp_q.pop_front();
               c = cyc_q.pop_front();
               check("result", result_o, e);
               check("ready_cycle", 64'(cyc), 64'(c));
            end
         end
         ready_prev = ready_o;
      end
   end

   // Driver tasks
   task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int lat);
      int n;
      @(negedge clk);
      signed_div = sgn;
      op1        = a;
      op2        = b;
      start      = 1'b1;
      exp_q.push_back(exp);
      cyc_q.push_back(cyc + 1 + lat);
      @(negedge clk);
      op1        = $urandom;
      op2        = $urandom;
      signed_div = ~sgn;
      n = 0;
      while (!ready_o && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!ready_o) begin
         check("ready_timeout", {63'd0, ready_o}, 64'd1);
         if (exp_q.size() > 0) void'(exp_q.pop_front());
         if (cyc_q.size() > 0) void'(cyc_q.pop_front());
      end else begin
         repeat (2) @(negedge clk);
         check("hold_ready", {63'd0, ready_o}, 64'd1);
         check("hold_result", result_o, exp);
      end
      start = 1'b0;
      @(negedge clk);
      check("drop_ready", {63'd0, ready_o}, 64'd0);
      check("drop_result", result_o, 64'd0);
   endtask

   initial begin
      logic seen;
      rst        = 1'b1;
      start      = 1'b0;
      annul      = 1'b0;
      signed_div = 1'b0;
      op1        = '0;
      op2        = '0;
      repeat (3) @(negedge clk);
      check("reset_ready", {63'd0, ready_o}, 64'd0);
      check("reset_result", result_o, 64'd0);
      check("reset_state", {62'd0, dbg_state_o}, 64'd0);
      rst = 1'b0;

      run_div(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33);
      run_div(1'b1, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 33);
      run_div(1'b1, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33);
      run_div(1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 64'hFFFFFFFE_0000000E, 33);
      run_div(1'b0, 32'h12345678, 32'h00000000, 64'h00000000_00000000, 1);
      run_div(1'b0, 32'hFFFFFFFF, 32'h00000001, 64'h00000000_FFFFFFFF, 33);
      run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33);
      run_div(1'b0, 32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000, 33);
      run_div(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFE, 64'h00000001_00000001, 33);

      // start together with annul is refused
      @(negedge clk);
      op1 = 32'd10; op2 = 32'd2; start = 1'b1; annul = 1'b1;
      @(negedge clk);
      check("annul_refuse_state", {62'd0, dbg_state_o}, 64'd0);
      start = 1'b0; annul = 1'b0;

      // annul mid-ON
      @(negedge clk);
      signed_div = 1'b0; op1 = 32'd1000; op2 = 32'd3; start = 1'b1;
      repeat (10) @(negedge clk);
      check("on_state", {62'd0, dbg_state_o}, 64'd2);
      annul = 1'b1; start = 1'b0;
      @(negedge clk);
      annul = 1'b0;
      check("annul_state", {62'd0, dbg_state_o}, 64'd0);
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         seen = seen | ready_o;
      end
      check("annul_no_ready", {63'd0, seen}, 64'd0);
      run_div(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33);

      // asynchronous reset mid-ON
      @(negedge clk);
      signed_div = 1'b0; op1 = 32'd1000; op2 = 32'd7; start = 1'b1;
      repeat (5) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("arst_on_ready", {63'd0, ready_o}, 64'd0);
      check("arst_on_result", result_o, 64'd0);
      check("arst_on_state", {62'd0, dbg_state_o}, 64'd0);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      run_div(1'b0, 32'd50, 32'd5, 64'h00000000_0000000A, 33);

      // asynchronous reset while a result is presented
      @(negedge clk);
      signed_div = 1'b0; op1 = 32'd77; op2 = 32'd0; start = 1'b1;
      exp_q.push_back(64'd0);
      cyc_q.push_back(cyc + 2);
      repeat (3) @(negedge clk);
      check("end_ready", {63'd0, ready_o}, 64'd1);
      #2 rst = 1'b1;
      #1;
      check("arst_end_ready", {63'd0, ready_o}, 64'd0);
      check("arst_end_state", {62'd0, dbg_state_o}, 64'd0);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      repeat (3) @(negedge clk);
      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
